hazard_control_unit: RTL and testbench

// - Pipeline sequencer for the 5-stage RV64 core (F/D/E/M/W).
// - Keeps its own scoreboard of destination registers per stage. Emits stall, flush and forwarding selects.
// - Sequences the multi-cycle mul/div unit in E. Branches resolve in decode (PCSF, PCTargetD), so D-stage compare operands are forwarded or stalled here.

---
 rtl/core_pkg.sv | 34 +++
 rtl/hcu_scoreboard.sv | 33 +++
 rtl/hazard_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings and scoreboard-entry layout for the hazard control unit
package core_pkg;

  localparam int DEF_REG_AW = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hcuState_t;

  // Entry layout: flag bits at the bottom, then rd, rs1, rs2 fields of aw bits each.
  localparam int SB_VALID = 0;
  localparam int SB_REGWR = 1;
  localparam int SB_MEMRD = 2;
  localparam int SB_MDOP  = 3;
  localparam int SB_RD    = 4;

  function automatic int sbRs1Lsb(input int aw);
    return SB_RD + aw;
  endfunction

  function automatic int sbRs2Lsb(input int aw);
    return SB_RD + 2 * aw;
  endfunction

  function automatic int sbWidth(input int aw);
    return SB_RD + 3 * aw;
  endfunction

endpackage

// File: rtl/hcu_scoreboard.sv
// rtl/hcu_scoreboard.sv - E/M/W destination-register scoreboard shift register
import core_pkg::*;

module hcu_scoreboard #(
  parameter int REG_AW = DEF_REG_AW,
  localparam int SBW = sbWidth(REG_AW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stallE,
  input  logic           flushE,
  input  logic           bubbleM,
  input  logic [SBW-1:0] entryD,
  output logic [SBW-1:0] entryE,
  output logic [SBW-1:0] entryM,
  output logic [SBW-1:0] entryW
);

  always_ff @(posedge clk) begin
    if (rst) begin
      entryE <= '0;
      entryM <= '0;
      entryW <= '0;
    end else begin
      if (!stallE) begin
        entryE <= flushE ? '0 : entryD;
      end
      entryM <= bubbleM ? '0 : entryE;
      entryW <= entryM;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/forward sequencer with mul/div wait FSM
import core_pkg::*;

module hazard_control_unit #(
  parameter int REG_AW     = DEF_REG_AW,
  parameter int MD_TIMEOUT = 64,
  parameter int ENABLE_FWD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InstrValidD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              UseRs1D,
  input  logic              UseRs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteEnD,
  input  logic              MemReadEnD,
  input  logic              BranchD,
  input  logic              MdOpD,
  input  logic              PCSF,
  input  logic              MdDoneE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              MdStartE,
  output logic              MdTimeoutErr
);

  localparam int SBW    = sbWidth(REG_AW);
  localparam int RS1LSB = sbRs1Lsb(REG_AW);
  localparam int RS2LSB = sbRs2Lsb(REG_AW);
  localparam int CW     = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);
  localparam logic FWD_ON = (ENABLE_FWD != 0);

  logic [SBW-1:0] entryD, entryE, entryM, entryW;
  hcuState_t state, stateNext;
  logic [CW-1:0] counter, cntNext;
  logic errQ, errSet, bubbleM;

  function automatic logic writes(input logic [SBW-1:0] e, input logic [REG_AW-1:0] r);
    return e[SB_VALID] && e[SB_REGWR] && (e[SB_RD +: REG_AW] != '0) && (e[SB_RD +: REG_AW] == r);
  endfunction

  // Unused sources are stored as x0 so E-stage forwarding never matches them.
  always_comb begin
    entryD = '0;
    entryD[SB_VALID] = InstrValidD;
    entryD[SB_REGWR] = RegWriteEnD;
    entryD[SB_MEMRD] = MemReadEnD;
    entryD[SB_MDOP]  = MdOpD;
    entryD[SB_RD +: REG_AW]  = RdD;
    entryD[RS1LSB +: REG_AW] = UseRs1D ? Rs1D : '0;
    entryD[RS2LSB +: REG_AW] = UseRs2D ? Rs2D : '0;
  end

  hcu_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .stallE (StallE),
    .flushE (FlushE),
    .bubbleM(bubbleM),
    .entryD (entryD),
    .entryE (entryE),
    .entryM (entryM),
    .entryW (entryW)
  );

  logic use1, use2, eHit1, eHit2, mHit1, mHit2, wHit1, wHit2;
  logic loadUse, branchRaw, hazStall, mdInE, mdWaitHold, mdAbort;
  logic [REG_AW-1:0] eRs1, eRs2;

  assign use1  = InstrValidD && UseRs1D;
  assign use2  = InstrValidD && UseRs2D;
  assign eHit1 = use1 && writes(entryE, Rs1D);
  assign eHit2 = use2 && writes(entryE, Rs2D);
  assign mHit1 = use1 && writes(entryM, Rs1D);
  assign mHit2 = use2 && writes(entryM, Rs2D);
  assign wHit1 = use1 && writes(entryW, Rs1D);
  assign wHit2 = use2 && writes(entryW, Rs2D);

  assign loadUse   = entryE[SB_MEMRD] && (eHit1 || eHit2);
  assign branchRaw = BranchD && (eHit1 || eHit2 || (entryM[SB_MEMRD] && (mHit1 || mHit2)));
  assign hazStall  = FWD_ON ? (loadUse || branchRaw)
                            : (eHit1 || eHit2 || mHit1 || mHit2 || wHit1 || wHit2);

  assign mdInE      = entryE[SB_VALID] && entryE[SB_MDOP];
  assign mdWaitHold = (state == MD_WAIT) && !MdDoneE;
  assign mdAbort    = mdWaitHold && (counter == CNT_LAST);
  // An aborted mul/div is flushed from E and must not reach M either.
  assign bubbleM    = StallE || mdAbort;

  assign eRs1 = entryE[RS1LSB +: REG_AW];
  assign eRs2 = entryE[RS2LSB +: REG_AW];

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (FWD_ON && !rst) begin
      if (entryE[SB_VALID]) begin
        if (writes(entryM, eRs1))      ForwardAE = FWD_M;
        else if (writes(entryW, eRs1)) ForwardAE = FWD_W;
        if (writes(entryM, eRs2))      ForwardBE = FWD_M;
        else if (writes(entryW, eRs2)) ForwardBE = FWD_W;
      end
      ForwardAD = BranchD && mHit1 && !entryM[SB_MEMRD];
      ForwardBD = BranchD && mHit2 && !entryM[SB_MEMRD];
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = counter;
    errSet    = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    MdStartE  = 1'b0;
    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      stateNext = RUN;
      cntNext   = '0;
    end else if (mdAbort) begin
      StallF    = 1'b1;
      StallD    = 1'b1;
      FlushE    = 1'b1;
      errSet    = 1'b1;
      stateNext = RUN;
    end else if (mdWaitHold) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      cntNext = counter + 1'b1;
    end else if (state == RUN && mdInE) begin
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      MdStartE  = 1'b1;
      cntNext   = '0;
      stateNext = MD_WAIT;
    end else begin
      // Normal RUN, or the MdDoneE cycle where E is released and hazards re-evaluated.
      stateNext = RUN;
      if (hazStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (PCSF) begin
        FlushD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      counter <= '0;
      errQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      counter <= cntNext;
      if (errSet) errQ <= 1'b1;
    end
  end

  assign MdTimeoutErr = errQ;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit with directed vectors
module tb_hazard_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, InstrValidD, UseRs1D, UseRs2D, RegWriteEnD, MemReadEnD, BranchD, MdOpD, PCSF, MdDoneE;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic StallF, StallD, StallE, FlushD, FlushE, ForwardAD, ForwardBD, MdStartE, MdTimeoutErr;
  logic [1:0] ForwardAE, ForwardBE;

  hazard_control_unit #(.REG_AW(5), .MD_TIMEOUT(64), .ENABLE_FWD(1)) dut (
    .clk(clk), .rst(rst), .InstrValidD(InstrValidD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RdD(RdD), .RegWriteEnD(RegWriteEnD),
    .MemReadEnD(MemReadEnD), .BranchD(BranchD), .MdOpD(MdOpD), .PCSF(PCSF), .MdDoneE(MdDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdStartE(MdStartE), .MdTimeoutErr(MdTimeoutErr)
  );

  typedef struct {
    string      name;
    logic [12:0] exp;
    logic [12:0] mask;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int failures = 0;

  localparam logic [12:0] ALL   = 13'h1fff;
  localparam logic [12:0] NOERR = 13'h1ffe;

  logic [12:0] act;
  assign act = {StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE,
                ForwardAD, ForwardBD, MdStartE, MdTimeoutErr};

  // Bit order: sf sd se fd fe fae[1:0] fbe[1:0] fad fbd start err
  function automatic logic [12:0] ex(input logic sf, sd, se, fd, fe, input logic [1:0] fae, fbe,
                                     input logic fad, fbd, st, err);
    return {sf, sd, se, fd, fe, fae, fbe, fad, fbd, st, err};
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (q.size() != 0) begin
      r = q.pop_front();
      checks++;
      if ((act & r.mask) !== (r.exp & r.mask)) begin
        failures++;
        $display("FAIL %s: got %b expected %b (mask %b)", r.name, act, r.exp, r.mask);
      end
    end
  end

  task automatic setD(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                      input logic u2, input logic [4:0] rd, input logic we, ld, br, md);
    InstrValidD = v; Rs1D = r1; UseRs1D = u1; Rs2D = r2; UseRs2D = u2;
    RdD = rd; RegWriteEnD = we; MemReadEnD = ld; BranchD = br; MdOpD = md;
  endtask

  task automatic nop();
    setD(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cycm(input string nm, input logic [12:0] e, input logic [12:0] m);
    q.push_back('{nm, e, m});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [12:0] e);
    cycm(nm, e, ALL);
  endtask

  task automatic idle(input int n, input logic err);
    nop();
    for (int i = 0; i < n; i++) cyc("idle", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; PCSF = 1'b0; MdDoneE = 1'b0;
    nop();
    @(posedge clk);
    #1;
    cyc("rst_hold0", ex(0,0,0,1,1,2'b00,2'b00,0,0,0,0));
    cyc("rst_hold1", ex(0,0,0,1,1,2'b00,2'b00,0,0,0,0));
    rst = 1'b0;

    // add x3,x1,x2 ; sub x4,x3,x5
    setD(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0); cyc("t1_add_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0, 0); cyc("t1_sub_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    nop();                                        cyc("t1_fwd_m", ex(0,0,0,0,0,2'b10,2'b00,0,0,0,0));
    cyc("t1_drain", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    idle(3, 1'b0);

    // lw x5,4(x2) ; add x6,x5,x1
    setD(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); cyc("t2_lw_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); cyc("t2_loaduse", ex(1,1,0,0,1,2'b00,2'b00,0,0,0,0));
    cyc("t2_release", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    nop();                                        cyc("t2_fwd_w", ex(0,0,0,0,0,2'b01,2'b00,0,0,0,0));
    idle(3, 1'b0);

    // addi x2,x0,1 ; beq x2,x3
    setD(1, 5'd0, 1, 5'd0, 0, 5'd2, 1, 0, 0, 0); cyc("t3_addi_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd2, 1, 5'd3, 1, 5'd0, 0, 0, 1, 0);
    PCSF = 1'b1;                                  cyc("t3_br_stall", ex(1,1,0,0,1,2'b00,2'b00,0,0,0,0));
    cyc("t3_br_fwd", ex(0,0,0,1,0,2'b00,2'b00,1,0,0,0));
    PCSF = 1'b0; nop();                           cyc("t3_br_in_e", ex(0,0,0,0,0,2'b01,2'b00,0,0,0,0));
    idle(3, 1'b0);

    // Writes to x0 followed by consumers of x0
    setD(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0); cyc("t6_add_x0", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0, 0); cyc("t6_use_x0a", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0); cyc("t6_lw_x0", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0); cyc("t6_use_x0b", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 1, 0); cyc("t6_beq_x0", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    idle(4, 1'b0);

    // mul x9,x1,x2 ; add x10,x9,x1 with MdDoneE five cycles after start
    setD(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0, 1); cyc("t4_mul_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd9, 1, 5'd1, 1, 5'd10, 1, 0, 0, 0); cyc("t4_start", ex(1,1,1,0,0,2'b00,2'b00,0,0,1,0));
    for (int i = 0; i < 4; i++) cyc("t4_wait", ex(1,1,1,0,0,2'b00,2'b00,0,0,0,0));
    MdDoneE = 1'b1;                               cyc("t4_done", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    MdDoneE = 1'b0; nop();                        cyc("t4_fwd_m", ex(0,0,0,0,0,2'b10,2'b00,0,0,0,0));
    idle(3, 1'b0);

    // mul x11 with no MdDoneE: watchdog abort after 64 wait cycles
    setD(1, 5'd1, 1, 5'd2, 1, 5'd11, 1, 0, 0, 1); cyc("to_mul_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    nop();                                         cyc("to_start", ex(1,1,1,0,0,2'b00,2'b00,0,0,1,0));
    for (int i = 0; i < 63; i++) cyc("to_wait", ex(1,1,1,0,0,2'b00,2'b00,0,0,0,0));
    cyc("to_abort", ex(1,1,0,0,1,2'b00,2'b00,0,0,0,0));
    cyc("to_err_set", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,1));
    idle(2, 1'b1);

    // rst during MD_WAIT
    setD(1, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 1); cyc("r_mul_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,1));
    nop();                                         cyc("r_start", ex(1,1,1,0,0,2'b00,2'b00,0,0,1,1));
    cyc("r_wait", ex(1,1,1,0,0,2'b00,2'b00,0,0,0,1));
    rst = 1'b1;                                    cycm("r_rst_md", ex(0,0,0,1,1,2'b00,2'b00,0,0,0,0), NOERR);
    rst = 1'b0;                                    cyc("r_after_md", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    idle(2, 1'b0);

    // rst during a load-use stall
    setD(1, 5'd1, 1, 5'd0, 0, 5'd13, 1, 1, 0, 0); cyc("r_lw_d", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    setD(1, 5'd13, 1, 5'd1, 1, 5'd14, 1, 0, 0, 0); cyc("r_loaduse", ex(1,1,0,0,1,2'b00,2'b00,0,0,0,0));
    rst = 1'b1;                                    cyc("r_rst_ld", ex(0,0,0,1,1,2'b00,2'b00,0,0,0,0));
    rst = 1'b0;                                    cyc("r_after_ld", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));
    nop();                                         cyc("r_after_ld2", ex(0,0,0,0,0,2'b00,2'b00,0,0,0,0));

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
